modport_ram: RTL and testbench



---
 rtl/modport_ram_if.sv | 23 ++
 rtl/modport_ram.sv | 39 +++
 tb/tb_modport_ram.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/modport_ram_if.sv
// Bus bundle for the 16x8 dual-port RAM.
// master drives the write and read requests. slave is the RAM side and returns read data.
interface modport_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/modport_ram.sv
// Dual-port synchronous RAM: one write port and one registered read port on a shared clock.
// When a read and a write hit the same address in the same cycle, the read returns the
// old word (read-first). Reset clears every word and the read register.
module modport_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input logic          clk,
  input logic          rst,
  modport_ram_if.slave bus
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_data_p1;

  // Storage: reset clears all words, otherwise an enabled write updates one word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.wr_enb) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read stage p1: capture the pre-write word, and hold the last value while rd_enb is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data_p1 <= '0;
    end else if (bus.rd_enb) begin
      r_rd_data_p1 <= r_mem[bus.rd_addr];
    end
  end

  assign bus.rd_data = r_rd_data_p1;

endmodule

// File: tb/tb_modport_ram.sv
// Directed self-checking bench for modport_ram.
// A reference memory model produces the expected read data. Expected values are queued
// when a cycle is driven and compared after the clock edge that produces them.
module tb_modport_ram;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  modport_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  modport_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [0:15];
  logic [7:0] exp_rd;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(input logic [7:0] obs, input logic [7:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the expected value for the edge just taken and compare it with rd_data.
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check(bus.rd_data, e.val, e.tag);
    end
  endtask

  // One normal cycle. It is called at posedge+1 and returns at the next posedge+1.
  task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic re, input logic [3:0] ra, input string tag);
    rst         = 1'b0;
    bus.wr_enb  = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_enb  = re;
    bus.rd_addr = ra;
    if (re) exp_rd = model[ra];
    if (we) model[wa] = wd;
    sb.push_back(exp_t'{val: exp_rd, tag: $sformatf("%s@%0d", tag, ra)});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Reset cycles. The enables may be active, and reset must override them.
  task automatic reset_cyc(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                           input logic re, input logic [3:0] ra, input int n);
    for (int c = 0; c < n; c++) begin
      rst         = 1'b1;
      bus.wr_enb  = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.rd_enb  = re;
      bus.rd_addr = ra;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
      exp_rd = 8'h00;
      sb.push_back(exp_t'{val: 8'h00, tag: "reset_rd_data"});
      @(posedge clk);
      #1;
      pop_check();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    bus.wr_enb  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_enb  = 1'b0;
    bus.rd_addr = '0;
    exp_rd      = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    @(posedge clk);
    #1;

    // Reset for 2 cycles, then every location reads 0
    reset_cyc(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2);
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), "reset_read");
      check(bus.rd_data, 8'h00, $sformatf("reset_read_const@%0d", a));
    end

    // Basic write followed by a read
    step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, "basic_write");
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, "basic_read");
    check(bus.rd_data, 8'hA5, "basic_read_const");

    // Full sweep: write addr^5A, then read back from 15 down to 0
    for (int a = 0; a < 16; a++)
      step(1'b1, 4'(a), 8'(a) ^ 8'h5A, 1'b0, 4'd0, "sweep_write");
    for (int a = 15; a >= 0; a--) begin
      step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), "sweep_read");
      check(bus.rd_data, 8'(a) ^ 8'h5A, $sformatf("sweep_const@%0d", a));
    end

    // Same-address collision: the read gets the old word, the next read gets the new word
    step(1'b1, 4'd7, 8'h11, 1'b0, 4'd0, "coll_prep");
    step(1'b1, 4'd7, 8'h22, 1'b1, 4'd7, "coll_same_cycle");
    check(bus.rd_data, 8'h11, "coll_old_const");
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, "coll_next");
    check(bus.rd_data, 8'h22, "coll_new_const");

    // Different-address write and read in the same cycle
    step(1'b1, 4'd9, 8'h3C, 1'b1, 4'd0, "diff_addr");
    check(bus.rd_data, 8'h5A, "diff_addr_rd_const");
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, "diff_addr_wr");
    check(bus.rd_data, 8'h3C, "diff_addr_wr_const");

    // Read hold: rd_data keeps its value while rd_enb is low, even if the word is overwritten
    step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, "hold_prep");
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, "hold_read");
    check(bus.rd_data, 8'hA5, "hold_read_const");
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'd3, 8'h00, 1'b0, 4'd0, "hold");
      check(bus.rd_data, 8'hA5, $sformatf("hold_const_%0d", c));
    end

    // Reset during traffic: fill memory, then reset while both enables are high
    for (int a = 0; a < 16; a++)
      step(1'b1, 4'(a), 8'(a) + 8'h80, 1'b0, 4'd0, "fill");
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd4, "fill_read");
    check(bus.rd_data, 8'h84, "fill_read_const");
    reset_cyc(1'b1, 4'd4, 8'hFF, 1'b1, 4'd4, 1);
    check(bus.rd_data, 8'h00, "midrst_rd_const");
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), "midrst_read");
      check(bus.rd_data, 8'h00, $sformatf("midrst_const@%0d", a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
